fetch_sequencer: RTL and testbench

Parametrised program sequencer for the core. Replaces the fixed 8-bit PC plus the "instruction pointer == 0" done detection with a start/done handshaked state machine. Supports a writable branch-target table for absolute and relative branches, external stall, explicit halt, and a saturating cycle counter. It sits between the decoder/ALU flag logic, which drives branch and halt requests, and the instruction memory, which is driven by pc.

---
 rtl/fetch_sequencer_pkg.sv | 16 +
 rtl/branch_lut.sv | 32 +++
 rtl/fetch_sequencer.sv | 105 ++++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the decode logic that drives it.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_t;

  localparam int unsigned DefPcW  = 8;
  localparam int unsigned DefIdxW = 4;

  // Decoder raises halt when it sees this opcode.
  localparam logic [3:0] OpHalt = 4'hF;

endpackage

// File: rtl/branch_lut.sv
// Writable branch-target table: one synchronous write port, one combinational read port.
module branch_lut #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [PC_W-1:0] mem_q [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Same-index write and read in one cycle returns the old entry.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// Program sequencer: start/done handshake, table-driven branches, stall, halt, cycle counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W       = DefPcW,
  parameter int unsigned     IDX_W      = DefIdxW,
  parameter int unsigned     CNT_W      = 16,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter bit              WRAP_HALT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_take,
  input  logic             br_abs,
  input  logic [IDX_W-1:0] br_idx,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  seq_state_t       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [PC_W-1:0]  tgt;
  logic [PC_W-1:0]  pc_inc;

  branch_lut #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (br_idx),
    .rdata (tgt)
  );

  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (!stall) begin
            if (halt) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (br_take) begin
              // Relative offsets are two's complement; plain modular add covers both signs.
              pc_q <= br_abs ? tgt : pc_q + tgt;
            end else begin
              pc_q <= pc_inc;
              if (WRAP_HALT && (pc_inc == '0)) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: driver predicts each post-edge state from a behavioural model, monitor checks.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stall = 1'b0, halt = 1'b0;
  logic        br_take = 1'b0, br_abs = 1'b0, lut_we = 1'b0;
  logic [3:0]  br_idx = '0, lut_waddr = '0;
  logic [7:0]  lut_wdata = '0;
  logic [7:0]  pc, pc_s;
  logic        busy, done, busy_s, done_s;
  logic [15:0] cycle_cnt;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  fetch_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .br_take(br_take), .br_abs(br_abs), .br_idx(br_idx), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc(pc), .busy(busy),
    .done(done), .cycle_cnt(cycle_cnt)
  );

  fetch_sequencer #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .br_take(br_take), .br_abs(br_abs), .br_idx(br_idx), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc(pc_s), .busy(busy_s),
    .done(done_s), .cycle_cnt(cnt_s)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passes = 0;
  string phase = "reset";
  logic  rst_req = 1'b1;

  // Reference model: mode 0 idle, 1 run, 2 done; counter kept unbounded and clipped on output.
  int m_mode, m_pc, m_cnt;
  int m_tbl[16];

  function void model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    for (int i = 0; i < 16; i++) m_tbl[i] = 0;
  endfunction

  function void model_step();
    int t;
    t = m_tbl[br_idx];
    if (reset) begin
      model_reset();
    end else begin
      if (m_mode == 1) begin
        m_cnt = m_cnt + 1;
        if (!stall) begin
          if (halt) m_mode = 2;
          else if (br_take) m_pc = br_abs ? t : (m_pc + t) % 256;
          else if (m_pc == 255) begin
            m_pc   = 0;
            m_mode = 2;
          end else m_pc = m_pc + 1;
        end
      end else if (start) begin
        m_mode = 1;
        m_pc   = 0;
        m_cnt  = 0;
      end
      if (lut_we) m_tbl[lut_waddr] = int'(lut_wdata);
    end
  endfunction

  function exp_t model_exp();
    exp_t e;
    e.pc   = 8'(m_pc);
    e.busy = (m_mode == 1);
    e.done = (m_mode == 2);
    e.cnt  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e.cnt4 = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    return e;
  endfunction

  task automatic push_exp();
    exp_q.push_back(model_exp());
    name_q.push_back(phase);
  endtask

  task automatic cyc(input bit st, input bit s, input bit h, input bit b, input bit a,
                     input int idx, input bit we, input int wa, input int wd);
    @(negedge clk);
    reset     = rst_req;
    start     = st;
    stall     = s;
    halt      = h;
    br_take   = b;
    br_abs    = a;
    br_idx    = 4'(idx);
    lut_we    = we;
    lut_waddr = 4'(wa);
    lut_wdata = 8'(wd);
    model_step();
    push_exp();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    model_reset();
    push_exp();
    #2;
    reset   = 1'b1;
    rst_req = 1'b1;
  endtask

  // Monitor: compares after every clock edge and immediately after an asynchronous reset.
  initial begin
    exp_t        e;
    string       n;
    logic [59:0] got, want;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        n    = name_q.pop_front();
        got  = {pc, busy, done, cycle_cnt, pc_s, busy_s, done_s, cnt_s};
        want = {e.pc, e.busy, e.done, e.cnt, e.pc, e.busy, e.done, e.cnt4};
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s @%0t: got pc=%h busy=%b done=%b cnt=%0d sat(pc=%h b=%b d=%b cnt=%0d) want pc=%h busy=%b done=%b cnt=%0d cnt4=%0d",
                      n, $time, pc, busy, done, cycle_cnt, pc_s, busy_s, done_s, cnt_s,
                      e.pc, e.busy, e.done, e.cnt, e.cnt4);
      end
    end
  end

  initial begin
    model_reset();
    idle(2);
    rst_req = 1'b0;

    phase = "wrap";
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(256);
    idle(2);

    phase = "branch";
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 'h40);
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 'hFE);
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 'h10);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    cyc(0, 0, 0, 1, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 4, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 3, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 3, 0, 0, 0);
    idle(1);

    phase = "same_idx";
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 1, 1, 'h22);
    cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);

    phase = "saturate";
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(20);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    phase = "random";
    repeat (400) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
          $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end

    phase = "async_reset";
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 3, 'h77);
    idle(51);
    async_reset();
    idle(1);
    rst_req = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 3, 0, 0, 0);
    idle(2);

    phase = "drain";
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
